dmi_req_sequencer: RTL and testbench

Debug-request sequencer between the debug module's request FIFO and response FIFO. It pops one DMI request at a time from the request queue, issues it to the debug-module register bus with a req/gnt/rvalid handshake, and enforces a cycle timeout. It then pushes exactly one response per popped request into the response queue, and can flush both queues on a DMI reset.

---
 rtl/dmi_req_sequencer.sv | 124 ++++++++++++
 tb/tb_dmi_req_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dmi_req_sequencer.sv
// dmi_req_sequencer: pops DMI requests, runs them on the DM register bus with a timeout,
// and pushes exactly one response per popped request unless a DMI reset abandons it.
module dmi_req_sequencer #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       dmi_rst_i,
    input  logic                       req_empty_i,
    input  logic [ADDR_W+DATA_W+1:0]   req_data_i,
    output logic                       req_pop_o,
    input  logic                       rsp_full_i,
    output logic [DATA_W+1:0]          rsp_data_o,
    output logic                       rsp_push_o,
    output logic                       fifo_flush_o,
    output logic                       dm_req_o,
    output logic                       dm_we_o,
    output logic [ADDR_W-1:0]          dm_addr_o,
    output logic [DATA_W-1:0]          dm_wdata_o,
    input  logic                       dm_gnt_i,
    input  logic                       dm_rvalid_i,
    input  logic [DATA_W-1:0]          dm_rdata_i,
    input  logic                       dm_err_i,
    output logic                       busy_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;
    logic                expire;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            rdata_q <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
        end
    end

    assign expire = cnt_q == CW'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;
        case (state_q)
            IDLE: if (!req_empty_i) begin
                {addr_d, wdata_d, op_d} = req_data_i;
                cnt_d   = '0;
                rdata_d = '0;
                resp_d  = (req_data_i[1:0] == 2'd3) ? 2'd2 : 2'd0;
                state_d = (req_data_i[1:0] == OP_READ || req_data_i[1:0] == OP_WRITE) ? ISSUE : RESP;
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (dm_gnt_i) begin
                    state_d = WAIT;
                end else if (expire) begin
                    rdata_d = '0;
                    resp_d  = 2'd3;
                    state_d = RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (dm_rvalid_i) begin
                    rdata_d = (op_q == OP_READ) ? dm_rdata_i : '0;
                    resp_d  = dm_err_i ? 2'd2 : 2'd0;
                    state_d = RESP;
                end else if (expire) begin
                    rdata_d = '0;
                    resp_d  = 2'd3;
                    state_d = RESP;
                end
            end
            RESP: state_d = rsp_full_i ? RESP : IDLE;
            default: state_d = IDLE;
        endcase
        // DMI reset drops any in-flight request without a response
        if (dmi_rst_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        req_pop_o    = !rst_i && !dmi_rst_i && state_q == IDLE && !req_empty_i;
        rsp_push_o   = !rst_i && !dmi_rst_i && state_q == RESP && !rsp_full_i;
        fifo_flush_o = !rst_i && dmi_rst_i;
        dm_req_o     = !rst_i && !dmi_rst_i && state_q == ISSUE;
        dm_we_o      = op_q == OP_WRITE;
        dm_addr_o    = addr_q;
        dm_wdata_o   = wdata_q;
        rsp_data_o   = {rdata_q, resp_q};
        busy_o       = state_q != IDLE;
    end
endmodule

// File: tb/tb_dmi_req_sequencer.sv
// tb_dmi_req_sequencer: directed checks of the DMI request sequencer with TIMEOUT=8.
module tb_dmi_req_sequencer;
    logic        clk = 0;
    logic        rst_i, dmi_rst_i, req_empty_i, rsp_full_i;
    logic [40:0] req_data_i;
    logic        req_pop_o, rsp_push_o, fifo_flush_o;
    logic [33:0] rsp_data_o;
    logic        dm_req_o, dm_we_o, dm_gnt_i, dm_rvalid_i, dm_err_i, busy_o;
    logic [6:0]  dm_addr_o;
    logic [31:0] dm_wdata_o, dm_rdata_i;
    int          checks = 0;
    int          errors = 0;

    dmi_req_sequencer #(.ADDR_W(7), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .dmi_rst_i(dmi_rst_i),
        .req_empty_i(req_empty_i), .req_data_i(req_data_i), .req_pop_o(req_pop_o),
        .rsp_full_i(rsp_full_i), .rsp_data_o(rsp_data_o), .rsp_push_o(rsp_push_o),
        .fifo_flush_o(fifo_flush_o), .dm_req_o(dm_req_o), .dm_we_o(dm_we_o),
        .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o), .dm_gnt_i(dm_gnt_i),
        .dm_rvalid_i(dm_rvalid_i), .dm_rdata_i(dm_rdata_i), .dm_err_i(dm_err_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [40:0] mk(input logic [6:0] a, input logic [31:0] w, input logic [1:0] op);
        return {a, w, op};
    endfunction

    initial begin
        rst_i = 1; dmi_rst_i = 1; req_empty_i = 0; rsp_full_i = 0; req_data_i = mk(7'h11, 32'h0, 2'd1);
        dm_gnt_i = 0; dm_rvalid_i = 0; dm_rdata_i = 0; dm_err_i = 0;
        tick(); tick();
        chk("rst_pop", 64'(req_pop_o), 64'd0);
        chk("rst_flush", 64'(fifo_flush_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_rsp", 64'(rsp_data_o), 64'd0);
        chk("rst_dmreq", 64'(dm_req_o), 64'd0);
        rst_i = 0; dmi_rst_i = 0; req_empty_i = 1;
        tick();
        chk("idle_busy", 64'(busy_o), 64'd0);
        // READ 0x11
        req_empty_i = 0; req_data_i = mk(7'h11, 32'h0, 2'd1); #1;
        chk("rd_pop", 64'(req_pop_o), 64'd1);
        tick();
        req_empty_i = 1; dm_gnt_i = 1; #1;
        chk("rd_req", 64'(dm_req_o), 64'd1);
        chk("rd_we", 64'(dm_we_o), 64'd0);
        chk("rd_addr", 64'(dm_addr_o), 64'h11);
        chk("rd_busy", 64'(busy_o), 64'd1);
        tick();
        dm_gnt_i = 0; #1;
        chk("rd_req_drop", 64'(dm_req_o), 64'd0);
        tick();
        dm_rvalid_i = 1; dm_rdata_i = 32'hDEADBEEF; #1;
        chk("rd_nopush", 64'(rsp_push_o), 64'd0);
        tick();
        dm_rvalid_i = 0; #1;
        chk("rd_push", 64'(rsp_push_o), 64'd1);
        chk("rd_data", 64'(rsp_data_o), 64'({32'hDEADBEEF, 2'd0}));
        tick();
        chk("rd_idle", 64'(busy_o), 64'd0);
        // WRITE with error, NOP queued behind it
        req_empty_i = 0; req_data_i = mk(7'h10, 32'h1, 2'd2); #1;
        chk("wr_pop", 64'(req_pop_o), 64'd1);
        tick();
        req_data_i = mk(7'h0, 32'h0, 2'd0); dm_gnt_i = 1; #1;
        chk("wr_we", 64'(dm_we_o), 64'd1);
        chk("wr_wdata", 64'(dm_wdata_o), 64'h1);
        chk("wr_nopop", 64'(req_pop_o), 64'd0);
        tick();
        dm_gnt_i = 0; dm_rvalid_i = 1; dm_err_i = 1; dm_rdata_i = 32'h55;
        tick();
        dm_rvalid_i = 0; dm_err_i = 0; #1;
        chk("wr_push", 64'(rsp_push_o), 64'd1);
        chk("wr_data", 64'(rsp_data_o), 64'({32'h0, 2'd2}));
        tick();
        #1;
        chk("nop_pop", 64'(req_pop_o), 64'd1);
        chk("nop_nopush", 64'(rsp_push_o), 64'd0);
        tick();
        req_data_i = mk(7'h0, 32'h0, 2'd3); #1;
        chk("nop_push", 64'(rsp_push_o), 64'd1);
        chk("nop_data", 64'(rsp_data_o), 64'({32'h0, 2'd0}));
        tick();
        // reserved op
        chk("res_pop", 64'(req_pop_o), 64'd1);
        tick();
        req_empty_i = 1; #1;
        chk("res_push", 64'(rsp_push_o), 64'd1);
        chk("res_data", 64'(rsp_data_o), 64'({32'h0, 2'd2}));
        tick();
        // timeout: gnt never comes
        req_empty_i = 0; req_data_i = mk(7'h05, 32'h0, 2'd1);
        tick();
        req_empty_i = 1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to_req%0d", i), 64'(dm_req_o), 64'd1);
            tick();
        end
        chk("to_req_end", 64'(dm_req_o), 64'd0);
        chk("to_push", 64'(rsp_push_o), 64'd1);
        chk("to_data", 64'(rsp_data_o), 64'({32'h0, 2'd3}));
        dm_rvalid_i = 1; dm_rdata_i = 32'h1234;
        tick();
        chk("late_nopush", 64'(rsp_push_o), 64'd0);
        chk("late_idle", 64'(busy_o), 64'd0);
        dm_rvalid_i = 0;
        // rvalid on the last allowed cycle wins
        req_empty_i = 0;
        tick();
        req_empty_i = 1; dm_gnt_i = 1;
        tick();
        dm_gnt_i = 0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("lw_wait%0d", i), 64'(rsp_push_o | !busy_o), 64'd0);
            tick();
        end
        dm_rvalid_i = 1; dm_rdata_i = 32'hCAFEF00D;
        tick();
        dm_rvalid_i = 0; rsp_full_i = 1; req_empty_i = 0; req_data_i = mk(7'h22, 32'h0, 2'd1); #1;
        chk("lw_data", 64'(rsp_data_o), 64'({32'hCAFEF00D, 2'd0}));
        // response FIFO full for 5 cycles
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("full_push%0d", i), 64'(rsp_push_o), 64'd0);
            chk($sformatf("full_pop%0d", i), 64'(req_pop_o), 64'd0);
            chk($sformatf("full_data%0d", i), 64'(rsp_data_o), 64'({32'hCAFEF00D, 2'd0}));
            tick();
        end
        rsp_full_i = 0; #1;
        chk("full_release", 64'(rsp_push_o), 64'd1);
        tick();
        // dmi reset during WAIT
        chk("dr_pop", 64'(req_pop_o), 64'd1);
        tick();
        req_empty_i = 1; dm_gnt_i = 1;
        tick();
        dm_gnt_i = 0; dmi_rst_i = 1; #1;
        chk("dr_flush", 64'(fifo_flush_o), 64'd1);
        chk("dr_nopush", 64'(rsp_push_o), 64'd0);
        tick();
        dmi_rst_i = 0; #1;
        chk("dr_flush_off", 64'(fifo_flush_o), 64'd0);
        chk("dr_idle", 64'(busy_o), 64'd0);
        tick();
        chk("dr_nopush2", 64'(rsp_push_o), 64'd0);
        req_empty_i = 0; req_data_i = mk(7'h33, 32'h0, 2'd1);
        tick();
        req_empty_i = 1; dm_gnt_i = 1;
        tick();
        dm_gnt_i = 0; dm_rvalid_i = 1; dm_rdata_i = 32'hA5A5A5A5;
        tick();
        dm_rvalid_i = 0; #1;
        chk("dr_after_push", 64'(rsp_push_o), 64'd1);
        chk("dr_after_data", 64'(rsp_data_o), 64'({32'hA5A5A5A5, 2'd0}));
        tick();
        // async reset mid-ISSUE
        req_empty_i = 0; req_data_i = mk(7'h44, 32'h0, 2'd1);
        tick();
        req_empty_i = 1; #1;
        chk("ar_req", 64'(dm_req_o), 64'd1);
        rst_i = 1; #1;
        chk("ar_req_off", 64'(dm_req_o), 64'd0);
        chk("ar_busy", 64'(busy_o), 64'd0);
        chk("ar_addr", 64'(dm_addr_o), 64'd0);
        tick();
        rst_i = 0;
        tick();
        chk("ar_idle_pop", 64'(req_pop_o), 64'd0);
        tick();
        chk("ar_idle_busy", 64'(busy_o), 64'd0);
        req_empty_i = 0; req_data_i = mk(7'h0, 32'h0, 2'd0); #1;
        chk("ar_pop", 64'(req_pop_o), 64'd1);
        tick();
        req_empty_i = 1; #1;
        chk("ar_push", 64'(rsp_push_o), 64'd1);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
